load_store_unit: RTL
====================

Name: load_store_unit

Overview:
Multi-cycle load/store execution unit that replaces the combinational data-move stage. It computes effective addresses and handles byte, half and word accesses with sign/zero extension. It talks to data memory over a req/ack handshake with a timeout, and writes load results to the register file through a one-cycle write strobe. It sits in the execute stage beside alu and branch; the control unit stalls on busy and advances on done.

Parameters:
XLEN, 32, datapath and memory bus width in bits; legal values 32 or 64.
IMM_W, 21, immediate width; sign-extended to XLEN.
TIMEOUT, 15, maximum cycles mem_req is held without mem_ack before an error is raised; minimum 1.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
start  in  1  one-cycle launch pulse; sampled only in IDLE
opcode  in  3  access type (see Behaviour)
xs  in  XLEN  load base register / store data register
xd  in  XLEN  store base register
imm  in  IMM_W  signed address offset
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
err  out  1  one-cycle error pulse, coincident with done
mem_req  out  1  memory request, held until ack or timeout
mem_we  out  1  1 = write, 0 = read; valid while mem_req
mem_addr  out  XLEN  byte address; valid while mem_req
mem_wdata  out  XLEN  store data, replicated across lanes
mem_be  out  XLEN/8  byte-lane enables
mem_rdata  in  XLEN  read data; valid in the cycle mem_ack is high
mem_ack  in  1  memory acknowledge
rf_we  out  1  register-file write strobe, one cycle
rf_wdata  out  XLEN  load result, extended

Behaviour:
- Opcodes:
  - 000 SDW, 001 SDH, 010 SDB: 32/16/8-bit store.
  - 011 LDW: 32-bit load, sign-extended when XLEN=64.
  - 100 LDH, 101 LDB: sign-extended loads.
  - 110 LDBU, 111 LDHU: zero-extended loads.
- Effective address, computed and registered at start:
  - Stores: EA = xd + sext(imm).
  - Loads: EA = xs + sext(imm).
  - Arithmetic is modulo 2^XLEN.
- Lane select: lane = EA mod (XLEN/8), little-endian.
- Store byte enables:
  - Byte: 1<<lane.
  - Half: 2'b11<<lane.
  - Word: 4'hF<<lane.
- Store data: wdata = xs low byte/half/word replicated over the bus.
- Alignment: half requires EA[0]=0; word requires EA[1:0]=0. A misaligned access makes no memory request.
- FSM states: IDLE, REQ, ERR, FIN.
  - IDLE: start=1 and aligned -> REQ. start=1 and misaligned -> ERR. Otherwise stay.
  - REQ: mem_req=1, with mem_addr, mem_we, mem_be and mem_wdata stable. A wait counter is cleared on entry and incremented each cycle without ack.
    - mem_ack=1 -> FIN. For loads, mem_rdata is captured, lane-extracted and extended into rf_wdata.
    - Counter reaches TIMEOUT with no ack -> ERR.
  - FIN: done=1. For loads, rf_we=1 in the same cycle. Next state is IDLE.
  - ERR: done=1, err=1, rf_we=0. Next state is IDLE.
- Latency with zero-wait memory (ack in the first REQ cycle): start at cycle 0, mem_req at cycle 1, done/rf_we at cycle 2.
- Each wait cycle adds one cycle of latency.
- Timeout: mem_req is high for exactly TIMEOUT cycles, then done+err.
- Outputs are registered.
- In IDLE:
  - mem_req, done, err, rf_we and busy are 0.
  - mem_addr, mem_wdata, mem_be and rf_wdata hold their last values.
- Reset values: all outputs 0; state IDLE; counter 0.
- Reset mid-operation:
  - The next state is IDLE and mem_req is 0 from the following cycle.
  - No done or rf_we is issued for the aborted access.
  - A late mem_ack is ignored.
- start while busy: ignored. No queuing.
- mem_ack in IDLE, FIN or ERR: ignored.
- start in the FIN/ERR cycle: ignored. A new access needs start in IDLE.

Test Plan:
- Reset, then SDW with xd=0x100, imm=0x4, xs=0xDEADBEEF, ack on the first REQ cycle -> mem_addr=0x104, mem_we=1, mem_be=4'hF, mem_wdata=0xDEADBEEF; done at cycle 2; rf_we never asserted.
- LDB with xs=0x200, imm=-1 (0x1FFFFF), mem_rdata=0x80000000, ack after 3 wait cycles -> mem_addr=0x1FF, lane 3; rf_wdata=0xFFFFFF80; rf_we=done=1 at cycle 5.
- LDHU at EA=0x302, mem_rdata=0xBEEF1234 -> rf_wdata=0x0000BEEF. SDB at EA=0x301 with xs=0xAB -> mem_be=4'b0010, mem_wdata=0xABABABAB.
- LDW at EA=0x402 (misaligned) -> mem_req stays 0; done=err=1 at cycle 1; rf_we=0.
- SDH with mem_ack tied low, TIMEOUT=15 -> mem_req high for exactly 15 cycles, then done=err=1 for one cycle; busy falls the cycle after.
- Reset asserted mid-REQ on a load, mem_ack arrives the next cycle -> mem_req=0, busy=0, no rf_we/done. A second start pulse during busy produces no extra access.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store execute unit: effective-address generation, sub-word lane handling, req/ack memory access with timeout.
// Latency: done two cycles after start on a zero-wait ack, plus one per wait cycle; start is ignored while busy.
module load_store_unit #(
    parameter int XLEN    = 32,
    parameter int IMM_W   = 21,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [XLEN-1:0]   xs,
    input  logic [XLEN-1:0]   xd,
    input  logic [IMM_W-1:0]  imm,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [XLEN-1:0]   mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    output logic [XLEN/8-1:0] mem_be,
    input  logic [XLEN-1:0]   mem_rdata,
    input  logic              mem_ack,
    output logic              rf_we,
    output logic [XLEN-1:0]   rf_wdata
);

    localparam int NB     = XLEN / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = $clog2(TIMEOUT + 1);

    localparam logic [2:0] SDW  = 3'b000;
    localparam logic [2:0] SDH  = 3'b001;
    localparam logic [2:0] SDB  = 3'b010;
    localparam logic [2:0] LDW  = 3'b011;
    localparam logic [2:0] LDH  = 3'b100;
    localparam logic [2:0] LDB  = 3'b101;
    localparam logic [2:0] LDBU = 3'b110;
    localparam logic [2:0] LDHU = 3'b111;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [2:0]         op_q;

    function automatic logic [1:0] size_of(input logic [2:0] op);
        logic [1:0] sz;
        sz = SZ_BYTE;
        case (op)
            SDW, LDW:        sz = SZ_WORD;
            SDH, LDH, LDHU:  sz = SZ_HALF;
            SDB, LDB, LDBU:  sz = SZ_BYTE;
            default:         sz = SZ_BYTE;
        endcase
        return sz;
    endfunction

    // Launch-side decode, only consumed when start is taken in IDLE.
    logic              st_c;
    logic [1:0]        size_c;
    logic [XLEN-1:0]   imm_ext;
    logic [XLEN-1:0]   ea;
    logic [LANE_W-1:0] lane;
    logic              misaligned;
    logic [NB-1:0]     be_c;
    logic [XLEN-1:0]   wdata_c;

    always_comb begin
        st_c       = (opcode == SDW) || (opcode == SDH) || (opcode == SDB);
        size_c     = size_of(opcode);
        imm_ext    = XLEN'($signed(imm));
        ea         = (st_c ? xd : xs) + imm_ext;
        lane       = ea[LANE_W-1:0];
        misaligned = ((size_c == SZ_HALF) && ea[0]) ||
                     ((size_c == SZ_WORD) && (ea[1:0] != 2'b00));
        case (size_c)
            SZ_BYTE: begin
                be_c    = NB'(1) << lane;
                wdata_c = {NB{xs[7:0]}};
            end
            SZ_HALF: begin
                be_c    = NB'(3) << lane;
                wdata_c = {(XLEN/16){xs[15:0]}};
            end
            default: begin
                be_c    = NB'(15) << lane;
                wdata_c = {(XLEN/32){xs[31:0]}};
            end
        endcase
    end

    // Load return path: the held mem_addr still selects the lane during REQ.
    logic [XLEN-1:0] rshift;
    logic [XLEN-1:0] ld_data;

    always_comb begin
        rshift = mem_rdata >> {mem_addr[LANE_W-1:0], 3'b000};
        case (op_q)
            LDW:     ld_data = XLEN'($signed(rshift[31:0]));
            LDH:     ld_data = XLEN'($signed(rshift[15:0]));
            LDB:     ld_data = XLEN'($signed(rshift[7:0]));
            LDBU:    ld_data = XLEN'(rshift[7:0]);
            LDHU:    ld_data = XLEN'(rshift[15:0]);
            default: ld_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            wait_cnt  <= '0;
            op_q      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            rf_we     <= 1'b0;
            rf_wdata  <= '0;
        end else begin
            done  <= 1'b0;
            err   <= 1'b0;
            rf_we <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= opcode;
                        busy <= 1'b1;
                        if (misaligned) begin
                            state <= ERR;
                            done  <= 1'b1;
                            err   <= 1'b1;
                        end else begin
                            state     <= REQ;
                            mem_req   <= 1'b1;
                            mem_we    <= st_c;
                            mem_addr  <= ea;
                            mem_be    <= be_c;
                            mem_wdata <= wdata_c;
                            wait_cnt  <= '0;
                        end
                    end
                end
                REQ: begin
                    // An ack in the final allowed cycle still wins over the timeout.
                    if (mem_ack) begin
                        state   <= FIN;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        if (!mem_we) begin
                            rf_we    <= 1'b1;
                            rf_wdata <= ld_data;
                        end
                    end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                        state   <= ERR;
                        mem_req <= 1'b0;
                        done    <= 1'b1;
                        err     <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                FIN, ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
